nco_sweep_ctrl: RTL and testbench
=================================

Name: nco_sweep_ctrl

Overview:
Frequency-sweep sequencer that drives the 32-bit tuning word and enable of the NCO. It accepts a sweep configuration over a valid/ready port: start, stop, step, dwell and mode. On `go`, it steps the tuning word through the sweep, holding each value for a programmed number of clocks. It sits between the host/config logic and the NCO, replacing the constant tuning word with a scheduled chirp, sawtooth, triangle or CW tone.

Parameters:
FW, 32, tuning-word width (matches NCO frequency input)
DW, 16, dwell-counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept; high only in IDLE
cfg_start  in  FW  start tuning word
cfg_stop  in  FW  stop tuning word
cfg_step  in  FW  per-step increment
cfg_dwell  in  DW  clocks per frequency value
cfg_mode  in  2  00 single, 01 repeat-saw, 10 triangle, 11 CW
go  in  1  start pulse
abort  in  1  stop pulse
nco_freq  out  FW  tuning word to NCO
nco_en  out  1  NCO enable
busy  out  1  high when not IDLE
step_strobe  out  1  1-cycle pulse coincident with each nco_freq change after the first load
done  out  1  1-cycle pulse at each leg end

Behaviour:
- Reset (async, rst_n=0) values: state IDLE, nco_freq=0, nco_en=0, cfg_ready=1, busy=0, step_strobe=0, done=0, cfg_loaded=0, direction=up.
- Config capture:
  - Registered on cfg_valid&&cfg_ready; sets cfg_loaded.
  - If start>stop, the two are swapped at capture.
  - dwell=0 is stored as 1.
  - step=0 in any sweep mode behaves as CW.
- States: IDLE, RUN, LAST.
- IDLE:
  - go with cfg_loaded=1 starts a sweep; go with cfg_loaded=0 is ignored.
  - Latency: go at cycle t gives nco_freq=start, nco_en=1, busy=1 at t+1.
  - cfg_valid and go in the same cycle: the config is captured, and the sweep starts from the new values.
- RUN:
  - The dwell counter loads dwell_eff and decrements each clk; each value is held exactly dwell_eff cycles.
  - On terminal count, next = freq ± step, computed at FW+1 bits.
  - Up direction: if carry or next>=stop, freq=stop and the leg ends; otherwise freq=next.
  - Down direction: if borrow or next<=start, freq=start and the leg ends.
  - No arithmetic wrap ever reaches nco_freq.
- LAST (the final dwell of a leg at its clamped endpoint), at terminal count:
  - single: done=1, nco_en=0, go to IDLE; nco_freq holds stop.
  - repeat-saw: done=1, freq=start, step_strobe=1, back to RUN.
  - triangle: done=1, direction flips, freq=endpoint∓step (clamped), back to RUN.
- CW: nco_freq=start, nco_en=1 indefinitely; no step_strobe and no done.
- abort:
  - From any non-IDLE state: IDLE next cycle, nco_en=0, no done pulse, nco_freq holds its value.
  - abort beats go in the same cycle.
  - In IDLE, abort is a no-op.
- go while busy is ignored. cfg_valid while busy is stalled (cfg_ready=0).
- Reset mid-sweep returns all state to reset values immediately; cfg_loaded is cleared, so a new config is needed.

Decomposition:
- Package nco_ctrl_pkg:
  - FW/DW defaults.
  - Mode encodings: MODE_SINGLE, MODE_SAW, MODE_TRI, MODE_CW.
  - State enum: IDLE, RUN, LAST.
- Sub-module nco_sweep_step (combinational): inputs freq, step, start, stop, dir; outputs next_freq (clamped) and leg_end. It is unit-testable in isolation for carry/borrow clamping.

Test Plan:
1. Single up: start=0x01000000, stop=0x04000000, step=0x01000000, dwell=4, go at t.
   - Required: freq 0x01000000 @t+1, 0x02000000 @t+5, 0x03000000 @t+9, 0x04000000 @t+13.
   - Required: 3 step_strobe pulses; done and nco_en=0 @t+17.
2. Clamp: start=0x01000000, stop=0x05000000, step=0x03000000, dwell=1, mode single -> freq sequence 0x01000000, 0x04000000, 0x05000000, then done.
3. Triangle: start=0, stop=2, step=1, dwell=1 -> freq 0,1,2,1,0,1,2…, with done pulse on each arrival at 2 and at 0.
4. Overflow: start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x10, mode saw -> 0xFFFFFFF0, 0xFFFFFFFF, 0xFFFFFFF0…; never 0x00000000.
5. Abort: abort during RUN gives IDLE, nco_en=0 next cycle and no done. go+abort together in RUN stays IDLE-bound. cfg_valid while busy shows cfg_ready=0 and the config is not taken.
6. Reset mid-sweep:
   - Required: rst_n low async clears all outputs within the same cycle.
   - Required: go after reset without a new config is ignored (busy stays 0).
   - Also: start>stop config gets swapped; dwell=0 holds each value 1 cycle.

Source files
------------

// File: rtl/nco_ctrl_pkg.sv
// Shared types and encodings for the NCO frequency-sweep controller.
package nco_ctrl_pkg;

    localparam int unsigned FW_DEFAULT = 32;
    localparam int unsigned DW_DEFAULT = 16;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_CW     = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLast
    } state_e;

endpackage

// File: rtl/nco_sweep_step.sv
// One sweep step: adds or subtracts the step and clamps to the sweep endpoints.
module nco_sweep_step
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned FW = FW_DEFAULT
) (
    input  logic [FW-1:0] freq_i,
    input  logic [FW-1:0] step_i,
    input  logic [FW-1:0] start_i,
    input  logic [FW-1:0] stop_i,
    input  logic          dir_i,
    output logic [FW-1:0] next_freq_o,
    output logic          leg_end_o
);

    logic [FW:0] sum;

    // The extra MSB is carry (up) or borrow (down); either one forces the clamp.
    always_comb begin
        sum         = '0;
        next_freq_o = freq_i;
        leg_end_o   = 1'b0;
        if (dir_i == DIR_UP) begin
            sum = {1'b0, freq_i} + {1'b0, step_i};
            if (sum[FW] || (sum[FW-1:0] >= stop_i)) begin
                next_freq_o = stop_i;
                leg_end_o   = 1'b1;
            end else begin
                next_freq_o = sum[FW-1:0];
            end
        end else begin
            sum = {1'b0, freq_i} - {1'b0, step_i};
            if (sum[FW] || (sum[FW-1:0] <= start_i)) begin
                next_freq_o = start_i;
                leg_end_o   = 1'b1;
            end else begin
                next_freq_o = sum[FW-1:0];
            end
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: schedules the NCO tuning word as single/saw/triangle sweeps or CW.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned FW = FW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [FW-1:0] cfg_start_i,
    input  logic [FW-1:0] cfg_stop_i,
    input  logic [FW-1:0] cfg_step_i,
    input  logic [DW-1:0] cfg_dwell_i,
    input  logic [1:0]    cfg_mode_i,
    input  logic          go_i,
    input  logic          abort_i,
    output logic [FW-1:0] nco_freq_o,
    output logic          nco_en_o,
    output logic          busy_o,
    output logic          step_strobe_o,
    output logic          done_o
);

    state_e        state_q, state_d;
    logic [FW-1:0] freq_q, freq_d;
    logic          en_q, en_d;
    logic          strobe_q, strobe_d;
    logic          done_q, done_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          loaded_q;
    logic [FW-1:0] start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    mode_q;

    logic          cfg_take, cw, tc, step_dir, leg_end;
    logic [FW-1:0] cap_start, cap_stop, start_e, next_freq;
    logic [DW-1:0] cap_dwell, dwell_e;

    assign cfg_ready_o = (state_q == StIdle);
    assign cfg_take    = cfg_valid_i && cfg_ready_o;
    assign cap_start   = (cfg_start_i > cfg_stop_i) ? cfg_stop_i : cfg_start_i;
    assign cap_stop    = (cfg_start_i > cfg_stop_i) ? cfg_start_i : cfg_stop_i;
    assign cap_dwell   = (cfg_dwell_i == '0) ? DW'(1) : cfg_dwell_i;
    // A config offered alongside go takes effect for that very sweep.
    assign start_e     = cfg_take ? cap_start : start_q;
    assign dwell_e     = cfg_take ? cap_dwell : dwell_q;
    assign cw          = (mode_q == MODE_CW) || (step_q == '0);
    assign tc          = (cnt_q == '0);
    // At a triangle turn-around the step is taken away from the endpoint just reached.
    assign step_dir    = (state_q == StLast) ? ~dir_q : dir_q;

    nco_sweep_step #(
        .FW(FW)
    ) u_step (
        .freq_i      (freq_q),
        .step_i      (step_q),
        .start_i     (start_q),
        .stop_i      (stop_q),
        .dir_i       (step_dir),
        .next_freq_o (next_freq),
        .leg_end_o   (leg_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= 1'b0;
            start_q  <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= DW'(1);
            mode_q   <= MODE_SINGLE;
        end else if (cfg_take) begin
            loaded_q <= 1'b1;
            start_q  <= cap_start;
            stop_q   <= cap_stop;
            step_q   <= cfg_step_i;
            dwell_q  <= cap_dwell;
            mode_q   <= cfg_mode_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        freq_d   = freq_q;
        en_d     = en_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            en_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go_i && !abort_i && (loaded_q || cfg_take)) begin
                        state_d = StRun;
                        freq_d  = start_e;
                        en_d    = 1'b1;
                        dir_d   = DIR_UP;
                        cnt_d   = dwell_e - DW'(1);
                    end
                end
                StRun: begin
                    if (!cw) begin
                        if (tc) begin
                            freq_d   = next_freq;
                            strobe_d = 1'b1;
                            cnt_d    = dwell_q - DW'(1);
                            if (leg_end) begin
                                state_d = StLast;
                            end
                        end else begin
                            cnt_d = cnt_q - DW'(1);
                        end
                    end
                end
                StLast: begin
                    if (tc) begin
                        done_d = 1'b1;
                        cnt_d  = dwell_q - DW'(1);
                        if (mode_q == MODE_SAW) begin
                            freq_d   = start_q;
                            strobe_d = 1'b1;
                            state_d  = StRun;
                        end else if (mode_q == MODE_TRI) begin
                            dir_d    = ~dir_q;
                            freq_d   = next_freq;
                            strobe_d = 1'b1;
                            state_d  = leg_end ? StLast : StRun;
                        end else begin
                            state_d = StIdle;
                            en_d    = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - DW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            freq_q   <= '0;
            en_q     <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= DIR_UP;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            en_q     <= en_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
        end
    end

    assign nco_freq_o    = freq_q;
    assign nco_en_o      = en_q;
    assign busy_o        = (state_q != StIdle);
    assign step_strobe_o = strobe_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: directed and random sweeps against a per-cycle trace model.
module tb_nco_sweep_ctrl;
    import nco_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_stop = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [1:0]  cfg_mode = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        cfg_ready;
    logic [31:0] nco_freq;
    logic        nco_en, busy, step_strobe, done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_freq[$];
    bit          exp_en[$];
    bit          exp_str[$];
    bit          exp_done[$];
    logic [31:0] obs_freq[$];
    int          obs_strobes;

    nco_sweep_ctrl #(
        .FW(32),
        .DW(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_start_i   (cfg_start),
        .cfg_stop_i    (cfg_stop),
        .cfg_step_i    (cfg_step),
        .cfg_dwell_i   (cfg_dwell),
        .cfg_mode_i    (cfg_mode),
        .go_i          (go),
        .abort_i       (abort),
        .nco_freq_o    (nco_freq),
        .nco_en_o      (nco_en),
        .busy_o        (busy),
        .step_strobe_o (step_strobe),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    function automatic longint lmin(input longint x, input longint y);
        return (x < y) ? x : y;
    endfunction

    function automatic longint lmax(input longint x, input longint y);
        return (x > y) ? x : y;
    endfunction

    function automatic void push_exp(input longint f, input bit en, input bit st, input bit dn);
        exp_freq.push_back(32'(f));
        exp_en.push_back(en);
        exp_str.push_back(st);
        exp_done.push_back(dn);
    endfunction

    // Trace model: list the frequency points of each leg, hold each for dwell cycles.
    function automatic void build_trace(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] s, input logic [15:0] d,
                                        input logic [1:0] m, input int n);
        longint lo, hi, st, cur;
        int     dw;
        bit     up, first, pend, stopped;
        exp_freq.delete();
        exp_en.delete();
        exp_str.delete();
        exp_done.delete();
        lo = (a < b) ? longint'(a) : longint'(b);
        hi = (a < b) ? longint'(b) : longint'(a);
        st = longint'(s);
        dw = (d == 16'd0) ? 1 : int'(d);
        if (m == MODE_CW || s == 32'd0) begin
            for (int i = 0; i < n; i++) push_exp(lo, 1'b1, 1'b0, 1'b0);
            return;
        end
        cur = lo; up = 1'b1; first = 1'b1; pend = 1'b0; stopped = 1'b0;
        while (exp_freq.size() < n) begin
            if (stopped) begin
                push_exp(cur, 1'b0, 1'b0, pend);
                pend = 1'b0;
            end else begin
                for (int k = 0; k < dw; k++) push_exp(cur, 1'b1, (k == 0) && !first, (k == 0) && pend);
                first = 1'b0;
                pend  = 1'b0;
                if (up ? (cur != hi) : (cur != lo)) begin
                    cur = up ? lmin(cur + st, hi) : lmax(cur - st, lo);
                end else begin
                    pend = 1'b1;
                    if (m == MODE_SINGLE) stopped = 1'b1;
                    else if (m == MODE_SAW) cur = lo;
                    else begin
                        up  = !up;
                        cur = up ? lmin(cur + st, hi) : lmax(cur - st, lo);
                    end
                end
            end
        end
    endfunction

    task automatic start_sweep(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                               input logic [15:0] d, input logic [1:0] m, input bit same);
        @(negedge clk);
        cfg_start = a; cfg_stop = b; cfg_step = s; cfg_dwell = d; cfg_mode = m;
        cfg_valid = 1'b1;
        if (!same) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        go = 1'b1;
        obs_freq.delete();
        obs_strobes = 0;
    endtask

    task automatic check_trace(input string name, input int from, input int to, input bit keep_cfg);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            go = 1'b0;
            if (!keep_cfg) cfg_valid = 1'b0;
            obs_freq.push_back(nco_freq);
            if (step_strobe === 1'b1) obs_strobes++;
            checks++;
            if (nco_freq !== exp_freq[i] || nco_en !== exp_en[i] || busy !== exp_en[i] ||
                cfg_ready !== !exp_en[i] || step_strobe !== exp_str[i] ||
                done !== exp_done[i]) begin
                errors++;
                $display("FAIL %s cyc %0d: got freq %h en %b busy %b rdy %b str %b done %b, want freq %h en %b busy %b rdy %b str %b done %b",
                         name, i, nco_freq, nco_en, busy, cfg_ready, step_strobe, done,
                         exp_freq[i], exp_en[i], exp_en[i], !exp_en[i], exp_str[i], exp_done[i]);
            end
        end
    endtask

    task automatic abort_check(input string name, input logic [31:0] f);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        go    = 1'b0;
        checks++;
        if (busy !== 1'b0 || nco_en !== 1'b0 || nco_freq !== f || done !== 1'b0 ||
            step_strobe !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got busy %b en %b freq %h done %b str %b rdy %b, want 0 0 %h 0 0 1",
                     name, busy, nco_en, nco_freq, done, step_strobe, cfg_ready, f);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (nco_freq !== 32'd0 || nco_en !== 1'b0 || busy !== 1'b0 || step_strobe !== 1'b0 ||
            done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: got freq %h en %b busy %b str %b done %b rdy %b, want 0 0 0 0 0 1",
                     nco_freq, nco_en, busy, step_strobe, done, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (busy !== 1'b0 || nco_en !== 1'b0) begin
            errors++;
            $display("FAIL go_unconfigured: got busy %b en %b, want 0 0", busy, nco_en);
        end
    endtask

    task automatic test_single_up();
        build_trace(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, MODE_SINGLE, 20);
        start_sweep(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd4, MODE_SINGLE, 1'b0);
        check_trace("single_up", 0, 20, 1'b0);
        checks++;
        if (obs_strobes != 3) begin
            errors++;
            $display("FAIL single_up_strobes: got %0d, want 3", obs_strobes);
        end
        checks++;
        if (obs_freq[12] !== 32'h0400_0000) begin
            errors++;
            $display("FAIL single_up_t13: got %h, want 04000000", obs_freq[12]);
        end
        abort_check("single_idle_abort", exp_freq[19]);
    endtask

    task automatic test_clamp();
        logic [31:0] want [3];
        want = '{32'h0100_0000, 32'h0400_0000, 32'h0500_0000};
        build_trace(32'h0100_0000, 32'h0500_0000, 32'h0300_0000, 16'd1, MODE_SINGLE, 6);
        start_sweep(32'h0100_0000, 32'h0500_0000, 32'h0300_0000, 16'd1, MODE_SINGLE, 1'b1);
        check_trace("clamp", 0, 6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_freq[i] !== want[i]) begin
                errors++;
                $display("FAIL clamp_seq %0d: got %h, want %h", i, obs_freq[i], want[i]);
            end
        end
    endtask

    task automatic test_triangle();
        logic [31:0] tri_seq [7];
        tri_seq = '{32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd1, 32'd2};
        build_trace(32'd0, 32'd2, 32'd1, 16'd1, MODE_TRI, 14);
        start_sweep(32'd0, 32'd2, 32'd1, 16'd1, MODE_TRI, 1'b0);
        check_trace("triangle", 0, 14, 1'b0);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (obs_freq[i] !== tri_seq[i]) begin
                errors++;
                $display("FAIL tri_seq %0d: got %h, want %h", i, obs_freq[i], tri_seq[i]);
            end
        end
        abort_check("tri_abort", exp_freq[13]);
    endtask

    task automatic test_overflow();
        bit zero_seen;
        build_trace(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd2, MODE_SAW, 16);
        start_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd2, MODE_SAW, 1'b0);
        check_trace("overflow", 0, 16, 1'b0);
        zero_seen = 1'b0;
        foreach (obs_freq[i]) if (obs_freq[i] == 32'd0) zero_seen = 1'b1;
        checks++;
        if (zero_seen !== 1'b0) begin
            errors++;
            $display("FAIL overflow_wrap: got zero_seen %b, want 0", zero_seen);
        end
        abort_check("overflow_abort", exp_freq[15]);
    endtask

    task automatic test_cw();
        build_trace(32'h1234, 32'h9000, 32'h100, 16'd2, MODE_CW, 8);
        start_sweep(32'h1234, 32'h9000, 32'h100, 16'd2, MODE_CW, 1'b0);
        check_trace("cw_mode", 0, 8, 1'b0);
        abort_check("cw_abort", exp_freq[7]);
        build_trace(32'h500, 32'h9000, 32'h0, 16'd1, MODE_SAW, 8);
        start_sweep(32'h500, 32'h9000, 32'h0, 16'd1, MODE_SAW, 1'b1);
        check_trace("step0_cw", 0, 8, 1'b0);
        abort_check("step0_abort", exp_freq[7]);
    endtask

    task automatic test_swap_dwell0();
        build_trace(32'h500, 32'h100, 32'h100, 16'd0, MODE_TRI, 20);
        start_sweep(32'h500, 32'h100, 32'h100, 16'd0, MODE_TRI, 1'b1);
        check_trace("swap_dwell0", 0, 20, 1'b0);
        abort_check("swap_abort", exp_freq[19]);
    endtask

    task automatic test_abort();
        build_trace(32'h1000, 32'h9000, 32'h1000, 16'd2, MODE_SAW, 12);
        start_sweep(32'h1000, 32'h9000, 32'h1000, 16'd2, MODE_SAW, 1'b0);
        check_trace("abort_run", 0, 1, 1'b0);
        cfg_start = 32'h7; cfg_stop = 32'h70; cfg_step = 32'h1; cfg_dwell = 16'd1;
        cfg_mode = MODE_CW;
        cfg_valid = 1'b1;
        check_trace("cfg_stall", 1, 7, 1'b1);
        cfg_valid = 1'b0;
        go = 1'b1;
        abort_check("go_abort", exp_freq[6]);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_abort: got busy %b, want 0", busy);
        end
        go = 1'b1;
        check_trace("replay_old_cfg", 0, 12, 1'b0);
        abort_check("replay_abort", exp_freq[11]);
    endtask

    task automatic test_reset_mid();
        build_trace(32'h10, 32'h100, 32'h8, 16'd3, MODE_SAW, 10);
        start_sweep(32'h10, 32'h100, 32'h8, 16'd3, MODE_SAW, 1'b1);
        check_trace("pre_reset", 0, 10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (nco_freq !== 32'd0 || nco_en !== 1'b0 || busy !== 1'b0 || step_strobe !== 1'b0 ||
            done !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got freq %h en %b busy %b str %b done %b rdy %b, want 0 0 0 0 0 1",
                     nco_freq, nco_en, busy, step_strobe, done, cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || nco_en !== 1'b0) begin
            errors++;
            $display("FAIL go_after_reset: got busy %b en %b, want 0 0", busy, nco_en);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, s, lo, hi;
        logic [15:0] d;
        logic [1:0]  m;
        for (int it = 0; it < 12; it++) begin
            do begin
                a = $urandom;
                b = $urandom;
            end while (a == b);
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            if ($urandom_range(0, 7) == 0) s = 32'd0;
            else s = ((hi - lo) >> $urandom_range(0, 3)) + 32'($urandom_range(1, 3));
            d = 16'($urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            build_trace(a, b, s, d, m, 30);
            start_sweep(a, b, s, d, m, 1'($urandom_range(0, 1)));
            check_trace("random", 0, 30, 1'b0);
            abort_check("random_abort", exp_freq[29]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_up();
        test_clamp();
        test_triangle();
        test_overflow();
        test_cw();
        test_swap_dwell0();
        test_abort();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
